// File: rtl/rvfi_commit_serializer.sv
// Serialises multi-port RVFI commit packets into one valid/ready stream.
// Each packet is tagged with a 64-bit sequence number. Drops are counted and made sticky.
package rvfi_pkg;
    typedef struct packed {
        logic        valid;
        logic [63:0] order;
        logic [31:0] insn;
        logic        trap;
        logic        halt;
        logic        intr;
        logic [1:0]  mode;
        logic [1:0]  ixl;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [31:0] rs1_rdata;
        logic [31:0] rs2_rdata;
        logic [4:0]  rd_addr;
        logic [31:0] rd_wdata;
        logic [31:0] pc_rdata;
        logic [31:0] pc_wdata;
        logic [31:0] mem_addr;
        logic [3:0]  mem_rmask;
        logic [3:0]  mem_wmask;
        logic [31:0] mem_rdata;
        logic [31:0] mem_wdata;
    } rvfi_instr_t;
endpackage

module rvfi_commit_serializer #(
    parameter int unsigned NR_COMMIT_PORTS = 2,
    parameter int unsigned DEPTH           = 8
) (
    input  logic                                        clk_i,
    input  logic                                        rst_i,
    input  rvfi_pkg::rvfi_instr_t [NR_COMMIT_PORTS-1:0] rvfi_i,
    output rvfi_pkg::rvfi_instr_t                       rvfi_o,
    output logic                                        valid_o,
    input  logic                                        ready_i,
    output logic [63:0]                                 order_o,
    output logic [$clog2(DEPTH):0]                      level_o,
    output logic                                        overflow_o,
    output logic [31:0]                                 drop_cnt_o
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;

    typedef struct packed {
        rvfi_pkg::rvfi_instr_t instr;
        logic [63:0]           tag;
    } entry_t;

    entry_t        mem_q [DEPTH];
    entry_t        mem_d [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [63:0]   seq_q, seq_d;
    logic          overflow_q, overflow_d;
    logic [31:0]   drop_cnt_q, drop_cnt_d;

    logic [LW-1:0] n_live;
    logic [LW-1:0] free;
    logic          pop;
    logic          accept;

    // NR_COMMIT_PORTS <= DEPTH, so the live count always fits the level width.
    always_comb begin
        n_live = '0;
        for (int unsigned i = 0; i < NR_COMMIT_PORTS; i++) begin
            if (rvfi_i[i].valid || rvfi_i[i].trap) begin
                n_live = n_live + LW'(1);
            end
        end
    end

    assign valid_o = (level_q != '0);
    assign pop     = valid_o && ready_i;
    assign free    = LW'(DEPTH) - level_q + LW'(pop);
    assign accept  = (n_live <= free);

    // Live packets are compacted into consecutive slots; seq advances even on a drop.
    always_comb begin
        logic [PW-1:0] slot;
        logic [63:0]   tag;
        mem_d = mem_q;
        slot  = wr_ptr_q;
        tag   = seq_q;
        for (int unsigned i = 0; i < NR_COMMIT_PORTS; i++) begin
            if (rvfi_i[i].valid || rvfi_i[i].trap) begin
                if (accept) begin
                    mem_d[slot].instr = rvfi_i[i];
                    mem_d[slot].tag   = tag;
                end
                slot = slot + PW'(1);
                tag  = tag + 64'd1;
            end
        end
        wr_ptr_d = accept ? slot : wr_ptr_q;
        seq_d    = tag;
    end

    always_comb begin
        logic [32:0] sum;
        rd_ptr_d   = rd_ptr_q + PW'(pop);
        level_d    = level_q + (accept ? n_live : '0) - LW'(pop);
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        sum        = {1'b0, drop_cnt_q} + 33'(n_live);
        if (!accept) begin
            overflow_d = 1'b1;
            drop_cnt_d = sum[32] ? '1 : sum[31:0];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_q      <= '{default: '0};
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            level_q    <= '0;
            seq_q      <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            mem_q      <= mem_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            level_q    <= level_d;
            seq_q      <= seq_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign rvfi_o     = valid_o ? mem_q[rd_ptr_q].instr : '0;
    assign order_o    = valid_o ? mem_q[rd_ptr_q].tag : '0;
    assign level_o    = level_q;
    assign overflow_o = overflow_q;
    assign drop_cnt_o = drop_cnt_q;

endmodule
